dot_matrix_scanner: RTL and testbench

//  Downstream of the XY tracker: consumes pixelX/pixelY (3b each) and drives a row-multiplexed
//  8x8 LED matrix, lighting exactly one dot. Time-multiplexes rows with a prescaler.

---
 rtl/dot_matrix_pkg.sv | 14 +
 rtl/scan_prescaler.sv | 32 +++
 rtl/dot_matrix_scanner.sv | 108 ++++++++++
 tb/tb_dot_matrix_scanner.sv | 133 +++++++++++++
 4 files changed

// File: rtl/dot_matrix_pkg.sv
// Shared constants and helpers for the dot-matrix display path.
//   MATRIX_N : rows/columns of the LED matrix
//   COORD_W  : width of a row or column coordinate
//   onehot8  : coordinate -> one-hot 8-bit drive pattern
package dot_matrix_pkg;

  localparam int MATRIX_N = 8;
  localparam int COORD_W  = 3;

  function automatic logic [MATRIX_N-1:0] onehot8(input logic [COORD_W-1:0] idx);
    onehot8 = 8'h01 << idx;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Free-running prescaler: pc counts 0..PRESCALE-1 and wraps; tick is high
// for the single cycle in which pc == PRESCALE-1.
// Ports:
//   CLK  in   system clock, rising edge
//   RST  in   asynchronous, active-low reset
//   pc   out  current prescaler count
//   tick out  combinational, one cycle per PRESCALE clocks
module scan_prescaler
  import dot_matrix_pkg::*;
#(
  parameter int PRESCALE = 1000,
  localparam int PC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1
) (
  input  logic            CLK,
  input  logic            RST,
  output logic [PC_W-1:0] pc,
  output logic            tick
);

  assign tick = (pc == PC_W'(PRESCALE - 1));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pc <= '0;
    end else if (tick) begin
      pc <= '0;
    end else begin
      pc <= pc + 1'b1;
    end
  end

endmodule

// File: rtl/dot_matrix_scanner.sv
// Row-multiplexed 8x8 LED matrix driver that lights a single dot.
// Coordinates are latched only at the frame boundary so the dot never tears;
// each row period starts with BLANK_CYCLES of rowSel=0 to suppress ghosting;
// the dot optionally blinks with a half-period of BLINK_FRAMES frames.
// Ports:
//   CLK        in   system clock, rising edge
//   RST        in   asynchronous, active-low reset
//   pixelX     in   dot column 0..7
//   pixelY     in   dot row 0..7
//   blinkEn    in   1 = blink the dot, 0 = steady
//   rowSel     out  one-hot row drive, zero while blanking
//   colData    out  column drive, bit pixelX set on the dot's row
//   rowIdx     out  row currently being scanned
//   frameStart out  one-cycle pulse at each frame boundary
// All outputs are registered: the value in cycle n decodes the state of cycle n-1.
module dot_matrix_scanner
  import dot_matrix_pkg::*;
#(
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 2,
  parameter int BLINK_FRAMES = 32
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [2:0]   pixelX,
  input  logic [2:0]   pixelY,
  input  logic         blinkEn,
  output logic [7:0]   rowSel,
  output logic [7:0]   colData,
  output logic [2:0]   rowIdx,
  output logic         frameStart
);

  localparam int PC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  if (PRESCALE < BLANK_CYCLES + 1) begin : gBadPrescale
    $error("dot_matrix_scanner: PRESCALE must be >= BLANK_CYCLES+1");
  end

  logic [PC_W-1:0]    pc;
  logic               tick;
  logic [COORD_W-1:0] row;
  logic [COORD_W-1:0] latX;
  logic [COORD_W-1:0] latY;
  logic [FC_W-1:0]    frameCnt;
  logic               visible;
  logic               wrap;
  logic               visEff;
  logic               blanking;

  scan_prescaler #(.PRESCALE(PRESCALE)) uPrescaler (
    .CLK  (CLK),
    .RST  (RST),
    .pc   (pc),
    .tick (tick)
  );

  assign wrap     = tick && (row == 3'd7);
  // Steady mode must show the dot on the very next output cycle, so the
  // blink enable gates visibility directly rather than through the register.
  assign visEff   = visible || !blinkEn;
  assign blanking = (int'(pc) < BLANK_CYCLES);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      row        <= '0;
      latX       <= '0;
      latY       <= '0;
      frameCnt   <= '0;
      visible    <= 1'b1;
      rowSel     <= '0;
      colData    <= '0;
      rowIdx     <= '0;
      frameStart <= 1'b0;
    end else begin
      if (tick) begin
        row <= row + 3'd1;
      end

      // Coordinates only move at the frame boundary; a new position and a
      // blink toggle on the same edge both take effect from row 0.
      if (wrap) begin
        latX <= pixelX;
        latY <= pixelY;
      end

      if (!blinkEn) begin
        frameCnt <= '0;
        visible  <= 1'b1;
      end else if (wrap) begin
        if (frameCnt == FC_W'(BLINK_FRAMES - 1)) begin
          frameCnt <= '0;
          visible  <= ~visible;
        end else begin
          frameCnt <= frameCnt + 1'b1;
        end
      end

      rowIdx     <= row;
      rowSel     <= blanking ? 8'h00 : onehot8(row);
      // colData is deliberately not blanked; rowSel alone gates the LEDs.
      colData    <= (visEff && (row == latY)) ? onehot8(latX) : 8'h00;
      frameStart <= wrap;
    end
  end

endmodule

// File: tb/tb_dot_matrix_scanner.sv
// Directed bench for dot_matrix_scanner with PRESCALE=4, BLANK_CYCLES=1,
// BLINK_FRAMES=2. After reset release, output cycle k reflects scan state
// s=k-1: row=(s/4)%8, pc=s%4, frame boundary when s%32==31.
module tb_dot_matrix_scanner;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [2:0] pixelX = 3'd0;
  logic [2:0] pixelY = 3'd0;
  logic       blinkEn = 1'b0;
  logic [7:0] rowSel;
  logic [7:0] colData;
  logic [2:0] rowIdx;
  logic       frameStart;

  int compared = 0;
  int mismatched = 0;

  // clock/reset block
  always #5 CLK = ~CLK;

  dot_matrix_scanner #(
    .PRESCALE     (4),
    .BLANK_CYCLES (1),
    .BLINK_FRAMES (2)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .pixelX     (pixelX),
    .pixelY     (pixelY),
    .blinkEn    (blinkEn),
    .rowSel     (rowSel),
    .colData    (colData),
    .rowIdx     (rowIdx),
    .frameStart (frameStart)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic [7:0] eRow, input logic [7:0] eCol,
                          input logic [2:0] eIdx, input logic eFs);
    check($sformatf("%s.rowSel", tag), rowSel, eRow);
    check($sformatf("%s.colData", tag), colData, eCol);
    check($sformatf("%s.rowIdx", tag), {5'b0, rowIdx}, {5'b0, eIdx});
    check($sformatf("%s.frameStart", tag), {7'b0, frameStart}, {7'b0, eFs});
  endtask

  task automatic nextCycle();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    int s;
    int row;
    int pc;
    logic [2:0] lx;
    logic [2:0] ly;
    logic       vis;
    logic [7:0] eRow;
    logic [7:0] eCol;

    // 1: all outputs zero while reset is held for 3 clocks
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checkAll($sformatf("inReset%0d", i), 8'h00, 8'h00, 3'd0, 1'b0);
    end
    RST = 1'b1;
    pixelX = 3'd5;
    pixelY = 3'd2;
    checkAll("release", 8'h00, 8'h00, 3'd0, 1'b0);

    // 2..5: scan, dot placement, no tearing, blink, steady restore
    for (int k = 1; k <= 342; k++) begin
      nextCycle();
      s   = k - 1;
      row = (s / 4) % 8;
      pc  = s % 4;
      if (s < 32) begin
        lx = 3'd0; ly = 3'd0;
      end else if (s < 64) begin
        lx = 3'd5; ly = 3'd2;
      end else begin
        lx = 3'd5; ly = 3'd6;
      end
      if (s >= 96 && s < 313) vis = (((s - 96) / 64) % 2) == 0;
      else vis = 1'b1;
      eRow = (pc == 0) ? 8'h00 : (8'h01 << row);
      eCol = (vis && (row == int'(ly))) ? (8'h01 << lx) : 8'h00;
      checkAll($sformatf("cyc%0d", k), eRow, eCol, 3'(row), (s % 32) == 31);

      if (k == 40) pixelY = 3'd6;         // mid-frame move while rowIdx=1
      if (k == 96) blinkEn = 1'b1;        // blink from the start of a frame
      if (k == 313) blinkEn = 1'b0;       // drop inside an off frame on row 6
      if (k == 341) begin
        pixelX = 3'd3;
        pixelY = 3'd4;
      end
    end

    // 6: asynchronous reset while rowIdx=5, between clock edges
    check("preReset.rowIdx", {5'b0, rowIdx}, 8'd5);
    #2;
    RST = 1'b0;
    #1;
    checkAll("asyncReset", 8'h00, 8'h00, 3'd0, 1'b0);
    @(negedge CLK);
    @(negedge CLK);
    checkAll("heldReset", 8'h00, 8'h00, 3'd0, 1'b0);
    RST = 1'b1;
    checkAll("release2", 8'h00, 8'h00, 3'd0, 1'b0);
    // Latches cleared: the dot sits at (0,0) for the first frame.
    for (int k = 1; k <= 8; k++) begin
      nextCycle();
      s   = k - 1;
      row = s / 4;
      pc  = s % 4;
      eRow = (pc == 0) ? 8'h00 : (8'h01 << row);
      eCol = (row == 0) ? 8'h01 : 8'h00;
      checkAll($sformatf("restart%0d", k), eRow, eCol, 3'(row), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
